// File: rtl/not_bist_pkg.sv
// Shared types and constants for the inverter BIST controller.
// LFSR tap table is only consumed when NOT_BIST_LFSR_EN is defined.
package not_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZEROS,
        ONES,
        WALK1,
        WALK0,
        LFSR
    } phase_e;

    localparam int LFSR_COUNT = 64;

    // Tap positions are 1-based bit numbers; 0 means unused.
    function automatic logic [63:0] tap_bits(
        input int a,
        input int b,
        input int c = 0,
        input int d = 0,
        input int e = 0,
        input int f = 0
    );
        logic [63:0] m;
        m = '0;
        if (a > 0) m = m | (64'd1 << (a - 1));
        if (b > 0) m = m | (64'd1 << (b - 1));
        if (c > 0) m = m | (64'd1 << (c - 1));
        if (d > 0) m = m | (64'd1 << (d - 1));
        if (e > 0) m = m | (64'd1 << (e - 1));
        if (f > 0) m = m | (64'd1 << (f - 1));
        return m;
    endfunction

    function automatic logic [63:0] lfsr_taps(input int w);
        case (w)
            4:  return tap_bits(4, 3);
            5:  return tap_bits(5, 3);
            6:  return tap_bits(6, 5);
            7:  return tap_bits(7, 6);
            8:  return tap_bits(8, 6, 5, 4);
            9:  return tap_bits(9, 5);
            10: return tap_bits(10, 7);
            11: return tap_bits(11, 9);
            12: return tap_bits(12, 6, 4, 1);
            13: return tap_bits(13, 4, 3, 1);
            14: return tap_bits(14, 5, 3, 1);
            15: return tap_bits(15, 14);
            16: return tap_bits(16, 15, 13, 4);
            17: return tap_bits(17, 14);
            18: return tap_bits(18, 11);
            19: return tap_bits(19, 6, 2, 1);
            20: return tap_bits(20, 17);
            21: return tap_bits(21, 19);
            22: return tap_bits(22, 21);
            23: return tap_bits(23, 18);
            24: return tap_bits(24, 23, 22, 17);
            25: return tap_bits(25, 22);
            26: return tap_bits(26, 6, 2, 1);
            27: return tap_bits(27, 5, 2, 1);
            28: return tap_bits(28, 25);
            29: return tap_bits(29, 27);
            30: return tap_bits(30, 6, 4, 1);
            31: return tap_bits(31, 28);
            32: return tap_bits(32, 22, 2, 1);
            33: return tap_bits(33, 20);
            34: return tap_bits(34, 27, 2, 1);
            35: return tap_bits(35, 33);
            36: return tap_bits(36, 25);
            37: return tap_bits(37, 5, 4, 3, 2, 1);
            38: return tap_bits(38, 6, 5, 1);
            39: return tap_bits(39, 35);
            40: return tap_bits(40, 38, 21, 19);
            41: return tap_bits(41, 38);
            42: return tap_bits(42, 41, 20, 19);
            43: return tap_bits(43, 42, 38, 37);
            44: return tap_bits(44, 43, 18, 17);
            45: return tap_bits(45, 44, 42, 41);
            46: return tap_bits(46, 45, 26, 25);
            47: return tap_bits(47, 42);
            48: return tap_bits(48, 47, 21, 20);
            49: return tap_bits(49, 40);
            50: return tap_bits(50, 49, 24, 23);
            51: return tap_bits(51, 50, 36, 35);
            52: return tap_bits(52, 49);
            53: return tap_bits(53, 52, 38, 37);
            54: return tap_bits(54, 53, 18, 17);
            55: return tap_bits(55, 31);
            56: return tap_bits(56, 55, 35, 34);
            57: return tap_bits(57, 50);
            58: return tap_bits(58, 39);
            59: return tap_bits(59, 58, 38, 37);
            60: return tap_bits(60, 59);
            61: return tap_bits(61, 60, 46, 45);
            62: return tap_bits(62, 61, 6, 5);
            63: return tap_bits(63, 62);
            64: return tap_bits(64, 63, 61, 60);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/not_bist_patgen.sv
// Stimulus sequencer: zeros, ones, walking-one, walking-zero and,
// with NOT_BIST_LFSR_EN, a trailing run of LFSR vectors.
module not_bist_patgen
    import not_bist_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] vec_o,
    output logic [7:0]       idx_o,
    output logic             last_o
);

    localparam logic [6:0] BMAX = 7'(WIDTH - 1);
`ifdef NOT_BIST_LFSR_EN
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
`endif

    phase_e           phase_q, phase_d;
    logic [6:0]       bit_q, bit_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [7:0]       idx_q;

    always_comb begin
        phase_d = phase_q;
        bit_d   = bit_q;
        vec_d   = vec_q;
        unique case (phase_q)
            ZEROS: begin
                phase_d = ONES;
                vec_d   = '1;
            end
            ONES: begin
                phase_d = WALK1;
                bit_d   = '0;
                vec_d   = WIDTH'(1);
            end
            WALK1: begin
                if (bit_q == BMAX) begin
                    phase_d = WALK0;
                    bit_d   = '0;
                    vec_d   = ~WIDTH'(1);
                end else begin
                    bit_d = bit_q + 7'd1;
                    vec_d = vec_q << 1;
                end
            end
            WALK0: begin
                if (bit_q == BMAX) begin
`ifdef NOT_BIST_LFSR_EN
                    phase_d = LFSR;
                    bit_d   = '0;
                    vec_d   = WIDTH'(1);
`endif
                end else begin
                    bit_d = bit_q + 7'd1;
                    vec_d = {vec_q[WIDTH-2:0], 1'b1};
                end
            end
            LFSR: begin
`ifdef NOT_BIST_LFSR_EN
                bit_d = bit_q + 7'd1;
                vec_d = {vec_q[WIDTH-2:0], ^(vec_q & TAPS)};
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || load_i) begin
            phase_q <= ZEROS;
            bit_q   <= '0;
            vec_q   <= '0;
            idx_q   <= '0;
        end else if (adv_i) begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
            vec_q   <= vec_d;
            idx_q   <= idx_q + 8'd1;
        end
    end

`ifdef NOT_BIST_LFSR_EN
    assign last_o = (phase_q == LFSR) && (bit_q == 7'(LFSR_COUNT - 1));
`else
    assign last_o = (phase_q == WALK0) && (bit_q == BMAX);
`endif

    assign vec_o = vec_q;
    assign idx_o = idx_q;

endmodule

// File: rtl/not_bist_ctrl.sv
// BIST controller for a WIDTH-bit inverter: FSM, response check, counters.
// Build option NOT_BIST_LFSR_EN appends 64 LFSR vectors to each run.
module not_bist_ctrl
    import not_bist_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [7:0]       fail_index
);

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [7:0]       err_q, err_d;
    logic [7:0]       fidx_q, fidx_d;
    logic [WIDTH-1:0] resp_q;
    logic [WIDTH-1:0] exp_q;
    logic [7:0]       cidx_q;
    logic             chk_q;

    logic             accept;
    logic             adv;
    logic             last;
    logic             mis;
    logic [WIDTH-1:0] vec;
    logic [7:0]       idx;

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start && !rst;
    assign adv    = (state_q == RUN) && !last;

    not_bist_patgen #(
        .WIDTH(WIDTH)
    ) u_patgen (
        .clk   (clk),
        .rst   (rst),
        .load_i(accept),
        .adv_i (adv),
        .vec_o (vec),
        .idx_o (idx),
        .last_o(last)
    );

    // Response and expectation are both registered one cycle after drive.
    assign mis = chk_q && (resp_q != exp_q);

    always_comb begin
        err_d  = err_q;
        fidx_d = fidx_q;
        if (mis) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (err_q == 8'd0) fidx_d = cidx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fidx_q  <= 8'hFF;
            resp_q  <= '0;
            exp_q   <= '0;
            cidx_q  <= '0;
            chk_q   <= 1'b0;
        end else begin
            chk_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fidx_q  <= 8'hFF;
                    end
                end
                RUN: begin
                    chk_q  <= 1'b1;
                    resp_q <= dut_out;
                    exp_q  <= ~vec;
                    cidx_q <= idx;
                    err_q  <= err_d;
                    fidx_q <= fidx_d;
                    if (last) state_q <= DRAIN;
                end
                DRAIN: begin
                    err_q   <= err_d;
                    fidx_q  <= fidx_d;
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_d == 8'd0);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dut_in     = vec;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_index = fidx_q;

endmodule

// File: tb/tb_not_bist_ctrl.sv
// Directed bench for not_bist_ctrl (WIDTH=32) with an inverter model
// whose bits can be stuck at 0 or 1.
module tb_not_bist_ctrl;

    localparam int W = 32;
`ifdef NOT_BIST_LFSR_EN
    localparam int NV = 2 * W + 66;
`else
    localparam int NV = 2 * W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dut_in;
    logic [W-1:0] dut_out;
    logic         busy;
    logic         done;
    logic         pass;
    logic [7:0]   err_count;
    logic [7:0]   fail_index;
    logic [W-1:0] stk0 = '0;
    logic [W-1:0] stk1 = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign dut_out = (~dut_in & ~stk0) | stk1;

    not_bist_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_index(fail_index)
    );

    function automatic logic [W-1:0] vec_model(input int k);
        logic [W-1:0] one;
        one = W'(1);
        if (k == 0) return '0;
        if (k == 1) return '1;
        if (k < W + 2) return one << (k - 2);
        return ~(one << (k - W - 2));
    endfunction

    // Start is sampled at the next edge; returns #1 after it.
    task automatic start_run();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_chk++;
        if ({busy, done, pass} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {busy, done, pass});
        end
        n_chk++;
        if (dut_in !== '0) begin
            n_fail++;
            $display("FAIL reset_dut_in: got %h want 0", dut_in);
        end
        n_chk++;
        if (err_count !== 8'd0 || fail_index !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_cnt: got err=%0d fidx=%h want 0/FF",
                     err_count, fail_index);
        end
    endtask

    task automatic test_ideal();
        int cyc;
        stk0 = '0;
        stk1 = '0;
        start_run();
        n_chk++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ideal_busy: got busy=%b done=%b want 1/0", busy, done);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            if (cyc < 2 * W + 2) begin
                n_chk++;
                if (dut_in !== vec_model(cyc)) begin
                    n_fail++;
                    $display("FAIL ideal_vec%0d: got %h want %h",
                             cyc, dut_in, vec_model(cyc));
                end
            end
`ifdef NOT_BIST_LFSR_EN
            if (cyc == 2 * W + 2) begin
                n_chk++;
                if (dut_in !== W'(1)) begin
                    n_fail++;
                    $display("FAIL lfsr_vec0: got %h want 1", dut_in);
                end
            end
`endif
            @(posedge clk);
            #1;
            cyc++;
        end
        n_chk++;
        if (cyc != NV + 1) begin
            n_fail++;
            $display("FAIL ideal_latency: got %0d want %0d", cyc + 1, NV + 2);
        end
        n_chk++;
        if (pass !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ideal_pass: got pass=%b busy=%b want 1/0", pass, busy);
        end
        n_chk++;
        if (err_count !== 8'd0 || fail_index !== 8'hFF) begin
            n_fail++;
            $display("FAIL ideal_cnt: got err=%0d fidx=%h want 0/FF",
                     err_count, fail_index);
        end
`ifndef NOT_BIST_LFSR_EN
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (dut_in !== vec_model(NV - 1) || done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: got %h done=%b want %h 1",
                     dut_in, done, vec_model(NV - 1));
        end
`endif
    endtask

    task automatic test_stuck(input string nm, input logic [W-1:0] s0,
                              input logic [W-1:0] s1, input logic [7:0] fidx);
        int cyc;
        stk0 = s0;
        stk1 = s1;
        start_run();
        wait_done(cyc);
        n_chk++;
        if (cyc != NV + 1) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d", nm, cyc + 1, NV + 2);
        end
`ifdef NOT_BIST_LFSR_EN
        n_chk++;
        if (err_count < 8'd33) begin
            n_fail++;
            $display("FAIL %s_err: got %0d want >=33", nm, err_count);
        end
`else
        n_chk++;
        if (err_count !== 8'd33) begin
            n_fail++;
            $display("FAIL %s_err: got %0d want 33", nm, err_count);
        end
`endif
        n_chk++;
        if (fail_index !== fidx || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_fidx: got %h pass=%b want %h 0",
                     nm, fail_index, pass, fidx);
        end
        stk0 = '0;
        stk1 = '0;
    endtask

    task automatic test_midrun_reset();
        int cyc;
        stk0 = W'(1) << 5;
        start_run();
        repeat (19) @(posedge clk);
        #1;
        n_chk++;
        if (err_count == 8'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got err=%0d busy=%b want >0 1", err_count, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_chk++;
        if ({busy, done, pass} !== 3'b000 || dut_in !== '0) begin
            n_fail++;
            $display("FAIL mid_rst_flags: got %b %h want 000 0",
                     {busy, done, pass}, dut_in);
        end
        n_chk++;
        if (err_count !== 8'd0 || fail_index !== 8'hFF) begin
            n_fail++;
            $display("FAIL mid_rst_cnt: got %0d %h want 0 FF", err_count, fail_index);
        end
        stk0 = '0;
        start_run();
        wait_done(cyc);
        n_chk++;
        if (cyc != NV + 1 || pass !== 1'b1 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_rerun: got cyc=%0d pass=%b err=%0d want %0d 1 0",
                     cyc, pass, err_count, NV + 1);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        start_run();
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            start = (cyc == 10) || (cyc == NV);
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        n_chk++;
        if (cyc != NV + 1 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL run_start: got cyc=%0d pass=%b want %0d 1",
                     cyc, pass, NV + 1);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        stk1 = W'(1);
        start_run();
        wait_done(cyc);
        stk1 = '0;
        n_chk++;
        if (err_count == 8'd0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got err=%0d done=%b want >0 1", err_count, done);
        end
        start_run();
        n_chk++;
        if (err_count !== 8'd0 || fail_index !== 8'hFF || busy !== 1'b1 ||
            done !== 1'b0 || dut_in !== '0) begin
            n_fail++;
            $display("FAIL b2b_accept: got err=%0d fidx=%h busy=%b done=%b in=%h",
                     err_count, fail_index, busy, done, dut_in);
        end
        wait_done(cyc);
        n_chk++;
        if (cyc != NV + 1 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got cyc=%0d pass=%b want %0d 1",
                     cyc, pass, NV + 1);
        end
    endtask

    task automatic test_rst_priority();
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        n_chk++;
        if ({busy, done, pass} !== 3'b000 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_prio: got %b err=%0d want 000 0",
                     {busy, done, pass}, err_count);
        end
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || dut_in !== '0) begin
            n_fail++;
            $display("FAIL rst_prio_idle: got busy=%b in=%h want 0 0", busy, dut_in);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_ideal();
        test_stuck("sa0_b5", W'(1) << 5, '0, 8'd0);
        test_stuck("sa1_b0", '0, W'(1), 8'd1);
        test_midrun_reset();
        test_start_ignored();
        test_back_to_back();
        test_rst_priority();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
